// File: rtl/io_peripheral_responder_if.sv
// io_peripheral_responder_if: command/response and host FIFO signals of the responder
interface io_peripheral_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0] to_peripheral;
  logic [DATA_WIDTH-1:0] to_peripheral_data;
  logic to_peripheral_valid;
  logic [1:0] from_peripheral;
  logic [DATA_WIDTH-1:0] from_peripheral_data;
  logic from_peripheral_valid;
  logic [DATA_WIDTH-1:0] host_out_data;
  logic host_out_valid;
  logic host_out_ready;
  logic [DATA_WIDTH-1:0] host_in_data;
  logic host_in_valid;
  logic host_in_ready;
  modport slave (
    input to_peripheral, to_peripheral_data, to_peripheral_valid, host_out_ready, host_in_data, host_in_valid,
    output from_peripheral, from_peripheral_data, from_peripheral_valid, host_out_data, host_out_valid, host_in_ready
  );
  modport master (
    output to_peripheral, to_peripheral_data, to_peripheral_valid, host_out_ready, host_in_data, host_in_valid,
    input from_peripheral, from_peripheral_data, from_peripheral_valid, host_out_data, host_out_valid, host_in_ready
  );
endinterface

// File: rtl/io_peripheral_responder.sv
// io_peripheral_responder: command responder bridging a core to a host through TX/RX FIFOs
module io_peripheral_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_BITS = 3
) (
  input logic clock,
  input logic reset,
  io_peripheral_responder_if.slave bus
);
  localparam logic [DEPTH_BITS:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  logic [DATA_WIDTH-1:0] tx_mem [2**DEPTH_BITS];
  logic [DATA_WIDTH-1:0] rx_mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [DEPTH_BITS:0] tx_cnt, rx_cnt;
  logic [7:0] err_cnt;
  logic resp_valid;
  logic [1:0] resp_code;
  logic [DATA_WIDTH-1:0] resp_data;
  logic is_wr, is_rd, is_st, acc, tx_push, tx_pop, rx_push, rx_pop, fail;
  logic [1:0] nxt_code;
  logic [DATA_WIDTH-1:0] nxt_data, status;
  assign acc = bus.to_peripheral_valid && bus.to_peripheral != 2'b00;
  assign is_wr = bus.to_peripheral_valid && bus.to_peripheral == 2'b01;
  assign is_rd = bus.to_peripheral_valid && bus.to_peripheral == 2'b10;
  assign is_st = bus.to_peripheral_valid && bus.to_peripheral == 2'b11;
  // full/empty decisions use start-of-cycle counts, so same-cycle host activity cannot rescue a command
  assign tx_push = is_wr && tx_cnt != FULL;
  assign rx_pop = is_rd && rx_cnt != '0;
  assign tx_pop = tx_cnt != '0 && bus.host_out_ready;
  assign rx_push = bus.host_in_valid && rx_cnt != FULL;
  assign fail = (is_wr && !tx_push) || (is_rd && !rx_pop);
  assign nxt_code = fail ? 2'b10 : is_st ? 2'b11 : 2'b01;
  assign nxt_data = rx_pop ? rx_mem[rx_rd] : is_st ? status : '0;
  // status word: RX count low, TX count at bit 16, error count in the top byte
  always_comb begin
    status = '0;
    status[DEPTH_BITS:0] = rx_cnt;
    status[16+DEPTH_BITS:16] = tx_cnt;
    status[31:24] = err_cnt;
  end
  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr] <= bus.to_peripheral_data;
    if (rx_push) rx_mem[rx_wr] <= bus.host_in_data;
  end
  // pointers, counts, error counter and the registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      err_cnt <= '0;
      resp_valid <= 1'b0;
      resp_code <= '0;
      resp_data <= '0;
    end else begin
      tx_wr <= tx_wr + DEPTH_BITS'(tx_push);
      tx_rd <= tx_rd + DEPTH_BITS'(tx_pop);
      rx_wr <= rx_wr + DEPTH_BITS'(rx_push);
      rx_rd <= rx_rd + DEPTH_BITS'(rx_pop);
      tx_cnt <= tx_cnt + (DEPTH_BITS+1)'(tx_push) - (DEPTH_BITS+1)'(tx_pop);
      rx_cnt <= rx_cnt + (DEPTH_BITS+1)'(rx_push) - (DEPTH_BITS+1)'(rx_pop);
      err_cnt <= err_cnt + 8'(fail && err_cnt != 8'hFF);
      resp_valid <= acc;
      resp_code <= acc ? nxt_code : 2'b00;
      resp_data <= nxt_data;
    end
  end
  // a response still pending when reset rises is suppressed immediately
  assign bus.from_peripheral_valid = resp_valid && !reset;
  assign bus.from_peripheral = reset ? 2'b00 : resp_code;
  assign bus.from_peripheral_data = reset ? '0 : resp_data;
  assign bus.host_out_valid = tx_cnt != '0;
  assign bus.host_out_data = tx_mem[tx_rd];
  assign bus.host_in_ready = rx_cnt != FULL;
endmodule

// File: tb/tb_io_peripheral_responder.sv
// tb_io_peripheral_responder: directed stimulus checked against a queue-based model every cycle
module tb_io_peripheral_responder;
  localparam int DW = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  io_peripheral_responder_if #(.DATA_WIDTH(DW)) bus();
  io_peripheral_responder #(.DATA_WIDTH(DW), .DEPTH_BITS(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int err_m = 0;
  int txn, rxn;
  bit ev = 0;
  bit started = 0;
  logic [1:0] ec = 0;
  logic [31:0] ed = 0;
  always @(posedge clock) begin
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      err_m = 0;
      ev = 0;
      ec = 0;
      ed = 0;
      started = 1;
    end else begin
      txn = tx_q.size();
      rxn = rx_q.size();
      ev = 0;
      ec = 0;
      ed = 0;
      if (bus.to_peripheral_valid && bus.to_peripheral != 2'b00) begin
        ev = 1;
        if (bus.to_peripheral == 2'b01) begin
          ec = (txn < 8) ? 2'b01 : 2'b10;
          if (txn < 8) tx_q.push_back(bus.to_peripheral_data);
        end else if (bus.to_peripheral == 2'b10) begin
          ec = (rxn > 0) ? 2'b01 : 2'b10;
          if (rxn > 0) ed = rx_q.pop_front();
        end else begin
          ec = 2'b11;
          ed = 32'(err_m * 32'h0100_0000 + txn * 32'h0001_0000 + rxn);
        end
      end
      if (ec == 2'b10 && err_m < 255) err_m++;
      if (txn > 0 && bus.host_out_ready) void'(tx_q.pop_front());
      if (rxn < 8 && bus.host_in_valid) rx_q.push_back(bus.host_in_data);
    end
  end
  always @(negedge clock) begin
    if (started) begin
      chk("resp_valid", bus.from_peripheral_valid, (ev && !reset) ? 1 : 0);
      chk("resp_code", bus.from_peripheral, (ev && !reset) ? ec : 2'b00);
      chk("resp_data", bus.from_peripheral_data, (ev && !reset) ? ed : 0);
      chk("host_out_valid", bus.host_out_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk("host_out_data", bus.host_out_data, tx_q[0]);
      chk("host_in_ready", bus.host_in_ready, rx_q.size() != 8);
    end
  end
  task automatic idle();
    reset = 1'b0;
    bus.to_peripheral = 2'b00;
    bus.to_peripheral_valid = 1'b0;
    bus.to_peripheral_data = '0;
    bus.host_in_valid = 1'b0;
    bus.host_in_data = '0;
    bus.host_out_ready = 1'b0;
  endtask
  task automatic go(input logic r, input logic [1:0] c, input logic [31:0] d, input logic hiv,
                    input logic [31:0] hid, input logic hor);
    reset = r;
    bus.to_peripheral = c;
    bus.to_peripheral_valid = 1'b1;
    bus.to_peripheral_data = d;
    bus.host_in_valid = hiv;
    bus.host_in_data = hid;
    bus.host_out_ready = hor;
    @(posedge clock);
    #2;
    idle();
  endtask
  task automatic look();
    @(negedge clock);
    #1;
  endtask
  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    look();
    chk("rst_valid", bus.from_peripheral_valid, 0);
    chk("rst_code", bus.from_peripheral, 0);
    chk("rst_hov", bus.host_out_valid, 0);
    chk("rst_hir", bus.host_in_ready, 1);
    go(0, 2'b01, 32'hA5, 0, 0, 0);
    look();
    chk("wr_valid", bus.from_peripheral_valid, 1);
    chk("wr_code", bus.from_peripheral, 2'b01);
    chk("wr_data", bus.from_peripheral_data, 0);
    chk("wr_hov", bus.host_out_valid, 1);
    chk("wr_hod", bus.host_out_data, 32'hA5);
    go(0, 2'b00, 0, 0, 0, 1);
    look();
    chk("nop_valid", bus.from_peripheral_valid, 0);
    chk("drain_hov", bus.host_out_valid, 0);
    go(0, 2'b00, 0, 1, 32'h11, 0);
    go(0, 2'b00, 0, 1, 32'h22, 0);
    go(0, 2'b10, 0, 0, 0, 0);
    look();
    chk("rd1_code", bus.from_peripheral, 2'b01);
    chk("rd1_data", bus.from_peripheral_data, 32'h11);
    go(0, 2'b10, 0, 0, 0, 0);
    look();
    chk("rd2_code", bus.from_peripheral, 2'b01);
    chk("rd2_data", bus.from_peripheral_data, 32'h22);
    go(0, 2'b10, 0, 0, 0, 0);
    look();
    chk("rd3_code", bus.from_peripheral, 2'b10);
    chk("rd3_data", bus.from_peripheral_data, 0);
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st1_code", bus.from_peripheral, 2'b11);
    chk("st1_data", bus.from_peripheral_data, 32'h0100_0000);
    go(1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) go(0, 2'b01, 32'h100 + i, 0, 0, 0);
    look();
    chk("wr9_code", bus.from_peripheral, 2'b10);
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st_txfull", bus.from_peripheral_data, 32'h0108_0000);
    go(0, 2'b01, 32'hDEAD, 0, 0, 1);
    look();
    chk("wrfull_drain_code", bus.from_peripheral, 2'b10);
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st_tx7", bus.from_peripheral_data, 32'h0207_0000);
    for (int i = 0; i < 8; i++) go(0, 2'b00, 0, 1, 32'h200 + i, 0);
    look();
    chk("rxfull_hir", bus.host_in_ready, 0);
    go(0, 2'b10, 0, 1, 32'h99, 0);
    look();
    chk("rdfull_code", bus.from_peripheral, 2'b01);
    chk("rdfull_data", bus.from_peripheral_data, 32'h200);
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st_rx7", bus.from_peripheral_data, 32'h0207_0007);
    go(0, 2'b10, 0, 1, 32'h300, 0);
    for (int i = 0; i < 7; i++) go(0, 2'b00, 0, 0, 0, 1);
    go(0, 2'b10, 0, 0, 0, 0);
    reset = 1'b1;
    look();
    chk("rst_pending_valid", bus.from_peripheral_valid, 0);
    @(posedge clock);
    #2;
    idle();
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st_after_rst", bus.from_peripheral_data, 0);
    repeat (260) go(0, 2'b10, 0, 0, 0, 0);
    go(0, 2'b11, 0, 0, 0, 0);
    look();
    chk("st_err_sat", bus.from_peripheral_data, 32'hFF00_0000);
    go(0, 2'b00, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/io_peripheral_responder.md
IO_PERIPHERAL_RESPONDER -- requirements
Module: io_peripheral_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of command/response/host data words.
REQ-002 SHALL have parameter DEPTH_BITS, default 3, log2 of each FIFO depth (depth 8).
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: to_peripheral  in  2  core command code: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
REQ-007 Port: to_peripheral_data  in  DATA_WIDTH  WRITE payload.
REQ-008 Port: to_peripheral_valid  in  1  command strobe, one command per asserted cycle.
REQ-009 Port: from_peripheral  out  2  response code: 01 ACK/DATA, 10 ERROR, 11 STATUS.
REQ-010 Port: from_peripheral_data  out  DATA_WIDTH  response payload.
REQ-011 Port: from_peripheral_valid  out  1  response strobe, one cycle per response.
REQ-012 Port: host_out_data  out  DATA_WIDTH  TX FIFO head toward host.
REQ-013 Port: host_out_valid  out  1  TX FIFO non-empty.
REQ-014 Port: host_out_ready  in  1  host accepts host_out_data.
REQ-015 Port: host_in_data  in  DATA_WIDTH  word from host into RX FIFO.
REQ-016 Port: host_in_valid  in  1  host offers host_in_data.
REQ-017 Port: host_in_ready  out  1  RX FIFO not full.

Function
REQ-018 SHALL contain a TX FIFO (core->host) and an RX FIFO (host->core), each 2**DEPTH_BITS entries, with pointers wrapping modulo depth and counts ranging 0..2**DEPTH_BITS.
REQ-019 SHALL accept a command only in cycles with to_peripheral_valid=1; code 00 SHALL produce no response and no state change.
REQ-020 SHALL register every response: a command accepted at edge N drives from_peripheral_valid=1 during cycle N+1 only, so back-to-back commands yield back-to-back responses; from_peripheral/from_peripheral_data are 0 whenever from_peripheral_valid=0.
REQ-021 WRITE: if TX count < depth, push to_peripheral_data and respond 01 with data 0; else drop the word and respond 10 with data 0.
REQ-022 READ: if RX count > 0, pop head and respond 01 with the popped word; else respond 10 with data 0.
REQ-023 STATUS: respond 11 with data[DEPTH_BITS:0]=RX count, data[16+DEPTH_BITS:16]=TX count, data[31:24]=error count, all other bits 0.
REQ-024 SHALL keep an 8-bit error counter incremented on every 10 response, saturating at 255.
REQ-025 host_out_valid SHALL equal (TX count != 0); TX pop occurs on host_out_valid & host_out_ready.
REQ-026 host_in_ready SHALL equal (RX count != depth); RX push occurs on host_in_valid & host_in_ready.
REQ-027 Full/empty decisions SHALL use counts at the start of the cycle: WRITE to a full TX fails even if the host drains in the same cycle; READ from an empty RX fails even if the host pushes in the same cycle.
REQ-028 Simultaneous push and pop on one FIFO (both legal) SHALL leave its count unchanged and preserve FIFO order.
REQ-029 Data SHALL never be reordered, duplicated or lost except the dropped WRITE of REQ-021.

Reset
REQ-030 While reset=1 at a rising edge: counts, pointers, error counter cleared; from_peripheral_valid, from_peripheral, from_peripheral_data, host_out_valid = 0; host_in_ready = 1 from the cycle after reset.
REQ-031 A command presented in the same cycle as reset, or whose response is pending when reset asserts, SHALL produce no response; FIFO contents are discarded.

Verification
REQ-032 Reset, then WRITE 0xA5 -> next cycle from_peripheral=01, valid=1; host_out_valid=1, host_out_data=0xA5; host_out_ready=1 -> host_out_valid=0.
REQ-033 Host pushes 0x11,0x22; READ, READ, READ back-to-back -> responses 01/0x11, 01/0x22, 10/0x0 on consecutive cycles; STATUS -> 11 with data 0x01000000.
REQ-034 Nine WRITEs with host_out_ready=0 -> eight 01 responses, ninth 10; STATUS -> TX count 8 (data 0x01080000).
REQ-035 TX full, WRITE with host_out_ready=1 same cycle -> response 10, TX count 7 afterward; RX full (host_in_ready=0), READ plus host push same cycle -> host push refused, RX count 7.
REQ-036 Reset asserted the cycle after a READ of non-empty RX -> no response, STATUS after reset -> data 0x00000000.
